window_frame_ctrl: RTL and testbench

//  Frame sequencer and BRAM-port arbiter for the 3x3 RGB888 window generator.

---
 rtl/window_frame_ctrl.sv | 115 +++++++++++
 tb/tb_window_frame_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/window_frame_ctrl.sv
// window_frame_ctrl: frame sequencer and single-port BRAM arbiter for the 3x3 window generator.
// The loader owns the port in LOAD and the window generator owns it in RUN; every other state leaves the port idle.
module window_frame_ctrl #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272,
  parameter int DEPTH  = 130560
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iSkipLoad,
  input  logic              iAbort,
  input  logic              iWrValid,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrReady,
  output logic              oBramCs,
  output logic              oBramWe,
  output logic [ADDR_W-1:0] oBramAddr,
  output logic [DATA_W-1:0] oBramWdata,
  input  logic              iWinCs,
  input  logic [ADDR_W-1:0] iWinAddr,
  input  logic              iWinValid,
  output logic              oWinEn,
  output logic              oWinRst,
  input  logic              iDsAfull,
  output logic              oBusy,
  output logic              oDone,
  output logic [7:0]        oFrameCnt
);
  if (DEPTH != WIDTH * HEIGHT) begin : g_depth_chk
    $error("DEPTH must equal WIDTH*HEIGHT");
  end
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic              flush_q, flush_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              in_load, in_run, wr_fire, out_fire;
  assign in_load  = state_q == S_LOAD;
  assign in_run   = state_q == S_RUN;
  assign wr_fire  = in_load & iWrValid;
  assign out_fire = in_run & iWinValid & ~iDsAfull;
  // Port outputs decode from registered state so the two masters can never overlap.
  assign oWrReady   = in_load;
  assign oBramCs    = wr_fire | (in_run & iWinCs);
  assign oBramWe    = wr_fire;
  assign oBramAddr  = wr_fire ? wr_cnt_q : in_run ? iWinAddr : '0;
  assign oBramWdata = wr_fire ? iWrData : '0;
  assign oWinEn     = in_run & ~iDsAfull;
  assign oWinRst    = state_q != S_FLUSH;
  assign oBusy      = state_q != S_IDLE;
  assign oDone      = state_q == S_DONE;
  assign oFrameCnt  = frame_cnt_q;
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_d     = flush_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: if (iStart) begin
        state_d   = iSkipLoad ? S_RUN : S_LOAD;
        wr_cnt_d  = '0;
        out_cnt_d = '0;
      end
      S_LOAD: if (iAbort) begin
        state_d  = S_FLUSH;
        flush_d  = 1'b0;
        wr_cnt_d = '0;
      end else if (wr_fire) begin
        wr_cnt_d = wr_cnt_q == LAST ? '0 : wr_cnt_q + ADDR_W'(1);
        state_d  = wr_cnt_q == LAST ? S_RUN : S_LOAD;
      end
      S_RUN: if (iAbort) begin
        state_d   = S_FLUSH;
        flush_d   = 1'b0;
        out_cnt_d = '0;
      end else if (out_fire) begin
        out_cnt_d   = out_cnt_q == LAST ? '0 : out_cnt_q + ADDR_W'(1);
        state_d     = out_cnt_q == LAST ? S_DONE : S_RUN;
        frame_cnt_d = out_cnt_q == LAST ? frame_cnt_q + 8'd1 : frame_cnt_q;
      end
      S_DONE:  state_d = S_IDLE;
      // Two-cycle window reset: flush_q marks the second cycle.
      S_FLUSH: begin
        flush_d = 1'b1;
        state_d = flush_q ? S_IDLE : S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      out_cnt_q   <= '0;
      flush_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      out_cnt_q   <= out_cnt_d;
      flush_q     <= flush_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_window_frame_ctrl.sv
// tb_window_frame_ctrl: randomized frame-level checks of window_frame_ctrl on a 4x3 frame.
module tb_window_frame_ctrl;
  localparam int DW = 24, AW = 17, W = 4, H = 3, D = W * H;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 0, skip_load = 0, abort = 0, wr_valid = 0;
  logic [DW-1:0] wr_data = '0;
  logic          win_cs = 0, win_valid = 0, ds_afull = 0;
  logic [AW-1:0] win_addr = '0;
  logic          wr_ready, bram_cs, bram_we, win_en, win_rst, busy, done;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [7:0]    frame_cnt;
  int n_chk = 0, n_fail = 0, exp_frames = 0;
  window_frame_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .iClk(clk), .iRst(rst_n), .iStart(start), .iSkipLoad(skip_load), .iAbort(abort),
    .iWrValid(wr_valid), .iWrData(wr_data), .oWrReady(wr_ready),
    .oBramCs(bram_cs), .oBramWe(bram_we), .oBramAddr(bram_addr), .oBramWdata(bram_wdata),
    .iWinCs(win_cs), .iWinAddr(win_addr), .iWinValid(win_valid), .oWinEn(win_en),
    .oWinRst(win_rst), .iDsAfull(ds_afull), .oBusy(busy), .oDone(done), .oFrameCnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic port_quiet(input string tag);
    check({tag, "_cs"}, bram_cs, 0);
    check({tag, "_we"}, bram_we, 0);
    check({tag, "_addr"}, bram_addr, 0);
    check({tag, "_wdata"}, bram_wdata, 0);
    check({tag, "_win_en"}, win_en, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
  endtask
  task automatic idle_chk(input string tag);
    port_quiet(tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win_rst"}, win_rst, 1);
    check({tag, "_frames"}, frame_cnt, exp_frames % 256);
  endtask
  task automatic start_frame(input logic skip);
    @(negedge clk);
    start = 1; skip_load = skip; ds_afull = 0;
    #1 idle_chk("pre_start");
    @(negedge clk);
    start = 0; skip_load = 0;
    #1;
    check("start_wr_ready", wr_ready, !skip);
    check("start_win_en", win_en, skip);
    check("start_busy", busy, 1);
  endtask
  task automatic flush_chk();
    win_cs = 1; win_addr = AW'($urandom); wr_valid = 1; ds_afull = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      port_quiet("flush");
      check("flush_win_rst", win_rst, 0);
      check("flush_done", done, 0);
      check("flush_busy", busy, 1);
      @(negedge clk);
    end
    win_cs = 0; wr_valid = 0; abort = 1;
    #1 idle_chk("post_flush");
    @(negedge clk);
    abort = 0;
    #1 idle_chk("idle_abort_ignored");
  endtask
  // mode 0: back-to-back, 1: every other cycle, 2: random gaps
  task automatic load_frame(input int mode, input int abort_at, output bit aborted);
    int idx = 0, cyc = 0;
    aborted = 0;
    while (idx < D && cyc < 2000) begin
      wr_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      wr_data = DW'($urandom);
      abort = idx == abort_at;
      #1;
      check("load_wr_ready", wr_ready, 1);
      check("load_we", bram_we, wr_valid);
      check("load_cs", bram_cs, wr_valid);
      if (wr_valid) begin
        check("load_addr", bram_addr, idx);
        check("load_wdata", bram_wdata, wr_data);
      end
      cyc++;
      @(negedge clk);
      if (abort) begin
        abort = 0;
        aborted = 1;
        flush_chk();
        return;
      end
      if (wr_valid) idx++;
    end
    wr_valid = 0;
    check("load_len", idx, D);
  endtask
  // mode 0: always valid, 1: valid with a 10-cycle stall, 2: random valid and stalls
  task automatic run_frame(input int mode, input int abort_at);
    int acc = 0, cyc = 0;
    while (acc < D && cyc < 4000) begin
      win_cs = 1'($urandom); win_addr = AW'($urandom);
      win_valid = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      ds_afull = mode == 1 ? (cyc >= 3 && cyc < 13) : mode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
      start = 1'($urandom); skip_load = 1'($urandom);
      abort = acc == abort_at;
      #1;
      check("run_win_en", win_en, !ds_afull);
      check("run_cs", bram_cs, win_cs);
      check("run_we", bram_we, 0);
      check("run_addr", bram_addr, win_addr);
      check("run_wdata", bram_wdata, 0);
      check("run_done", done, 0);
      check("run_wr_ready", wr_ready, 0);
      check("run_busy", busy, 1);
      if (win_valid && !ds_afull) acc++;
      cyc++;
      @(negedge clk);
      start = 0; skip_load = 0;
      if (abort) begin
        abort = 0; win_valid = 0;
        flush_chk();
        return;
      end
    end
    win_cs = 0; win_valid = 0; ds_afull = 0;
    check("run_len", acc, D);
    abort = 1'($urandom);
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    port_quiet("done");
    exp_frames++;
    @(negedge clk);
    abort = 0;
    #1 idle_chk("after_done");
  endtask
  task automatic full_frame(input logic skip, input int lmode, input int rmode);
    bit ab;
    start_frame(skip);
    if (!skip) load_frame(lmode, -1, ab);
    run_frame(rmode, -1);
  endtask
  initial begin
    bit ab;
    repeat (3) @(negedge clk);
    #1 idle_chk("reset");
    rst_n = 1;
    full_frame(0, 0, 0);
    check("frames_t1", frame_cnt, 1);
    full_frame(1, 0, 0);
    check("frames_skip", frame_cnt, 2);
    full_frame(0, 1, 0);
    full_frame(1, 0, 1);
    start_frame(0);
    load_frame(2, -1, ab);
    run_frame(0, 5);
    start_frame(0);
    load_frame(0, 7, ab);
    check("load_aborted", ab, 1);
    for (int f = 0; f < 20; f++)
      full_frame(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    start_frame(0);
    wr_valid = 1;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    exp_frames = 0;
    idle_chk("mid_reset");
    wr_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int f = 0; f < 256; f++) begin
      full_frame(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      if (f == 254) check("frames_255", frame_cnt, 255);
    end
    check("frames_wrap", frame_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
